// File: rtl/spx_sign_seq.sv
// SPHINCS+ signing sequencer: gen_r, hash_msg, FORS, then per layer WOTS + treehash.
// Enables are registered one cycle after the triggering pulse; no backpressure, stray pulses ignored.
module spx_sign_seq #(
  parameter int SPX_D     = 8,
  parameter int TREE_H    = 8,
  parameter int TREE_BITS = (SPX_D - 1) * TREE_H,
  parameter int LAYER_W   = 4,
  parameter int WDOG_W    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 skip_fors,
  input  logic                 gen_r_done,
  input  logic                 hash_msg_done,
  input  logic [TREE_BITS-1:0] msg_tree,
  input  logic [TREE_H-1:0]    msg_leaf_idx,
  input  logic                 fors_done,
  input  logic                 wots_done,
  input  logic                 wots_thash_mode,
  input  logic                 treehash_done,
  input  logic                 sig_word_vld,
  output logic                 en_gen_r,
  output logic                 en_hash_msg,
  output logic                 en_fors,
  output logic                 en_wots,
  output logic                 en_treehash,
  output logic                 treehash_mode,
  output logic                 rst_auth,
  output logic                 root_sel,
  output logic [LAYER_W-1:0]   layer,
  output logic [TREE_BITS-1:0] wots_tree,
  output logic [TREE_H-1:0]    wots_leaf,
  output logic [2:0]           sha_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          sig_words
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN_R = 3'd1,
    S_HASH  = 3'd2,
    S_FORS  = 3'd3,
    S_WOTS  = 3'd4,
    S_TREE  = 3'd5
  } state_t;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(SPX_D - 1);
  // Expiry is taken one count early so err lands in the cycle the counter would read all-ones.
  localparam logic [WDOG_W-1:0]  WD_TERM    = {{(WDOG_W-1){1'b1}}, 1'b0};

  state_t              state;
  logic [WDOG_W-1:0]   wdog;
  logic                adv;
  logic                start_acc;

  assign start_acc     = (state == S_IDLE) && start;
  assign busy          = (state != S_IDLE);
  assign treehash_mode = (state == S_TREE);

  always_comb begin
    adv = 1'b0;
    case (state)
      S_GEN_R: adv = gen_r_done;
      S_HASH:  adv = hash_msg_done;
      S_FORS:  adv = fors_done;
      S_WOTS:  adv = wots_done;
      S_TREE:  adv = treehash_done;
      default: adv = 1'b0;
    endcase
  end

  assign rst_auth = !abort && (((state == S_HASH) && hash_msg_done && root_sel) ||
                               ((state == S_FORS) && fors_done));

  always_comb begin
    wots_tree = msg_tree >> (32'(layer) * TREE_H);
    if (layer == '0) wots_leaf = msg_leaf_idx;
    else             wots_leaf = TREE_H'(msg_tree >> ((32'(layer) - 32'd1) * TREE_H));
  end

  always_comb begin
    sha_sel = 3'd0;
    case (state)
      S_GEN_R: sha_sel = 3'd1;
      S_HASH:  sha_sel = 3'd2;
      S_FORS:  sha_sel = 3'd3;
      S_TREE:  sha_sel = 3'd3;
      S_WOTS:  sha_sel = wots_thash_mode ? 3'd3 : 3'd4;
      default: sha_sel = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      wdog        <= '0;
      layer       <= '0;
      root_sel    <= 1'b0;
      sig_words   <= '0;
      en_gen_r    <= 1'b0;
      en_hash_msg <= 1'b0;
      en_fors     <= 1'b0;
      en_wots     <= 1'b0;
      en_treehash <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      en_gen_r    <= 1'b0;
      en_hash_msg <= 1'b0;
      en_fors     <= 1'b0;
      en_wots     <= 1'b0;
      en_treehash <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;

      if (start_acc)
        sig_words <= {15'd0, sig_word_vld};
      else if (sig_word_vld && (sig_words != 16'hFFFF))
        sig_words <= sig_words + 16'd1;

      if (start_acc) root_sel <= skip_fors;

      if (state == S_IDLE) begin
        wdog  <= '0;
        layer <= '0;
        if (start) begin
          state    <= S_GEN_R;
          en_gen_r <= 1'b1;
        end
      end else if (abort) begin
        state <= S_IDLE;
        wdog  <= '0;
        layer <= '0;
      end else if (adv) begin
        wdog <= '0;
        case (state)
          S_GEN_R: begin
            state       <= S_HASH;
            en_hash_msg <= 1'b1;
          end
          S_HASH: begin
            if (root_sel) begin
              state   <= S_WOTS;
              en_wots <= 1'b1;
            end else begin
              state   <= S_FORS;
              en_fors <= 1'b1;
            end
          end
          S_FORS: begin
            state   <= S_WOTS;
            en_wots <= 1'b1;
          end
          S_WOTS: begin
            state       <= S_TREE;
            en_treehash <= 1'b1;
          end
          default: begin
            if (layer == LAST_LAYER) begin
              state <= S_IDLE;
              done  <= 1'b1;
              layer <= '0;
            end else begin
              state   <= S_WOTS;
              en_wots <= 1'b1;
              layer   <= layer + 1'b1;
            end
          end
        endcase
      end else if (wdog == WD_TERM) begin
        state <= S_IDLE;
        err   <= 1'b1;
        wdog  <= '0;
        layer <= '0;
      end else begin
        wdog <= wdog + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spx_sign_seq.sv
// Self-checking bench for spx_sign_seq: event-order scoreboard, arithmetic address model, corner sequences.
module tb_spx_sign_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, abort = 1'b0, skip_fors = 1'b0;
  logic        gen_r_done = 1'b0, hash_msg_done = 1'b0, fors_done = 1'b0;
  logic        wots_done = 1'b0, treehash_done = 1'b0, wots_thash_mode = 1'b0;
  logic        sig_word_vld = 1'b0;
  logic [55:0] msg_tree = '0;
  logic [7:0]  msg_leaf_idx = '0;
  logic        en_gen_r, en_hash_msg, en_fors, en_wots, en_treehash;
  logic        treehash_mode, rst_auth, root_sel, busy, done, err;
  logic [3:0]  layer;
  logic [55:0] wots_tree;
  logic [7:0]  wots_leaf;
  logic [2:0]  sha_sel;
  logic [15:0] sig_words;

  int n_cmp = 0;
  int n_bad = 0;

  logic [55:0] seen_tree [8];
  logic [7:0]  seen_leaf [8];

  typedef struct {
    int          lay;
    logic [55:0] tree;
    logic [7:0]  leaf;
  } addr_vec_t;
  addr_vec_t tbl [8];

  spx_sign_seq #(.SPX_D(8), .TREE_H(8), .LAYER_W(4), .WDOG_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .skip_fors(skip_fors),
    .gen_r_done(gen_r_done), .hash_msg_done(hash_msg_done), .msg_tree(msg_tree),
    .msg_leaf_idx(msg_leaf_idx), .fors_done(fors_done), .wots_done(wots_done),
    .wots_thash_mode(wots_thash_mode), .treehash_done(treehash_done),
    .sig_word_vld(sig_word_vld), .en_gen_r(en_gen_r), .en_hash_msg(en_hash_msg),
    .en_fors(en_fors), .en_wots(en_wots), .en_treehash(en_treehash),
    .treehash_mode(treehash_mode), .rst_auth(rst_auth), .root_sel(root_sel),
    .layer(layer), .wots_tree(wots_tree), .wots_leaf(wots_leaf), .sha_sel(sha_sel),
    .busy(busy), .done(done), .err(err), .sig_words(sig_words)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Address of layer l: tree index divided down by 2^(8*l); leaf is the byte just below it.
  function automatic void addr_model(input int l, output longint unsigned t, output longint unsigned lf);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < l; i++) p = p * 256;
    t = longint'(msg_tree) / p;
    if (l == 0) lf = longint'(msg_leaf_idx);
    else        lf = (longint'(msg_tree) / (p / 256)) % 256;
  endfunction

  function automatic logic [2:0] sha_model(input int phase, input logic thash);
    case (phase)
      1: return 3'd1;
      2: return 3'd2;
      3, 5: return 3'd3;
      4: return thash ? 3'd3 : 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // mode 0: normal run, 1: withhold fors_done, 2: abort + wots_done at first WOTS cycle of layer 2
  task automatic run_sig(input bit skip, input int dly, input int mode, input int vld_n, input bit stray);
    int ev[$];
    int exp_ev[$];
    int phase, due, which, lay, n_done, n_err, n_rst, t_fors, t_err, vcnt;
    bit fin, aborted;
    longint unsigned et, el;
    phase = 0; due = -1; which = 0; lay = -1; n_done = 0; n_err = 0; n_rst = 0;
    t_fors = -100; t_err = -1; vcnt = 0; fin = 0; aborted = 0;

    start = 1'b1; skip_fors = skip;
    sig_word_vld = (vld_n > 0);
    if (vld_n > 0) vcnt = 1;
    step();
    start = 1'b0; sig_word_vld = 1'b0;
    chk("sig_words_after_start", sig_words, vcnt);

    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      gen_r_done = 0; hash_msg_done = 0; fors_done = 0; wots_done = 0;
      treehash_done = 0; abort = 0; start = 0; sig_word_vld = 0;
      if (aborted) begin
        chk("abort_en_treehash", en_treehash, 0);
        chk("abort_busy", busy, 0);
        chk("abort_layer", layer, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        fin = 1;
      end
      if (en_gen_r)    begin ev.push_back(1); phase = 1; which = 1; due = cyc + dly; end
      if (en_hash_msg) begin ev.push_back(2); phase = 2; which = 2; due = cyc + dly; end
      if (en_fors) begin
        ev.push_back(3); phase = 3; t_fors = cyc; due = cyc + dly;
        which = (mode == 1) ? 0 : 3;
      end
      if (en_wots) begin
        ev.push_back(4); phase = 4; lay++; which = 4; due = cyc + dly;
        addr_model(lay, et, el);
        chk("layer", layer, lay);
        chk("wots_tree", wots_tree, et);
        chk("wots_leaf", wots_leaf, el);
        if (lay >= 0 && lay < 8) begin
          seen_tree[lay] = wots_tree;
          seen_leaf[lay] = wots_leaf;
        end
        if (mode == 2 && lay == 2) due = cyc;
      end
      if (en_treehash) begin ev.push_back(5); phase = 5; which = 5; due = cyc + dly; end
      if (done) begin n_done++; fin = 1; end
      if (err)  begin n_err++; t_err = cyc; fin = 1; end
      if (fin) phase = 0;

      if (!fin) begin
        if (which != 0 && cyc == due) begin
          case (which)
            1: gen_r_done = 1;
            2: hash_msg_done = 1;
            3: fors_done = 1;
            4: wots_done = 1;
            default: treehash_done = 1;
          endcase
          if (mode == 2 && which == 4 && lay == 2) begin abort = 1; aborted = 1; end
          which = 0;
        end
        if (stray && $urandom_range(0, 5) == 0) begin
          if (phase != 1) gen_r_done = 1;
          if (phase != 5) treehash_done = 1;
        end
        if (vcnt < vld_n) begin sig_word_vld = 1; vcnt++; end
        if (vld_n > 0 && cyc == 5) start = 1;
        wots_thash_mode = 1'($urandom_range(0, 1));
      end
      #1;
      chk("sha_sel", sha_sel, sha_model(phase, wots_thash_mode));
      chk("busy", busy, phase != 0);
      chk("treehash_mode", treehash_mode, phase == 5);
      if (rst_auth) n_rst++;
      if (!fin) step();
    end
    sig_word_vld = 0; start = 0;

    chk("run_finished", fin, 1);
    exp_ev.push_back(1);
    exp_ev.push_back(2);
    if (!skip) exp_ev.push_back(3);
    if (mode != 1) begin
      for (int l = 0; l < 8; l++) begin
        exp_ev.push_back(4);
        if (mode == 2 && l == 2) break;
        exp_ev.push_back(5);
      end
    end
    chk("enable_count", ev.size(), exp_ev.size());
    for (int i = 0; i < ev.size() && i < exp_ev.size(); i++) chk("enable_order", ev[i], exp_ev[i]);
    chk("done_count", n_done, (mode == 0) ? 1 : 0);
    chk("err_count", n_err, (mode == 1) ? 1 : 0);
    if (mode == 1) chk("wdog_latency", t_err - t_fors, 15);
    chk("rst_auth_count", n_rst, (mode == 1) ? 0 : 1);
    chk("end_layer", layer, 0);
    chk("end_busy", busy, 0);
    chk("end_sig_words", sig_words, (vcnt > 65535) ? 65535 : vcnt);
    chk("end_root_sel", root_sel, skip);
  endtask

  initial begin
    tbl[0] = '{0, 56'h0123456789ABCD, 8'h5A};
    tbl[1] = '{1, 56'h000123456789AB, 8'hCD};
    tbl[2] = '{2, 56'h00000123456789, 8'hAB};
    tbl[3] = '{3, 56'h00000001234567, 8'h89};
    tbl[4] = '{4, 56'h00000000012345, 8'h67};
    tbl[5] = '{5, 56'h00000000000123, 8'h45};
    tbl[6] = '{6, 56'h00000000000001, 8'h23};
    tbl[7] = '{7, 56'h00000000000000, 8'h01};

    rstn = 0;
    repeat (3) step();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_layer", layer, 0);
    chk("rst_sig_words", sig_words, 0);
    chk("rst_root_sel", root_sel, 0);
    chk("rst_enables", {en_gen_r, en_hash_msg, en_fors, en_wots, en_treehash}, 0);
    chk("rst_sha_sel", sha_sel, 0);
    rstn = 1;
    step();

    // Fixed-vector run, then per-layer addressing from the table.
    msg_tree = 56'h0123456789ABCD;
    msg_leaf_idx = 8'h5A;
    run_sig(0, 3, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("tbl_tree", seen_tree[tbl[i].lay], tbl[i].tree);
      chk("tbl_leaf", seen_leaf[tbl[i].lay], tbl[i].leaf);
    end

    // FORS bypass; root_sel holds until the next accepted start.
    run_sig(1, 3, 0, 0, 0);
    repeat (3) step();
    chk("root_sel_held", root_sel, 1);

    run_sig(0, 3, 1, 0, 0);   // watchdog
    run_sig(0, 3, 2, 0, 0);   // abort in WOTS layer 2
    run_sig(0, 2, 0, 20, 0);  // 20 signature words, start retriggered while busy
    run_sig(0, 3, 0, 0, 0);   // fresh start clears sig_words

    for (int r = 0; r < 6; r++) begin
      msg_tree = {24'($urandom), $urandom};
      msg_leaf_idx = 8'($urandom);
      run_sig(1'($urandom_range(0, 1)), $urandom_range(1, 10), 0, $urandom_range(0, 30), 1);
    end

    // start together with abort in IDLE is accepted.
    step();
    start = 1; abort = 1;
    step();
    start = 0; abort = 0;
    chk("idle_abort_start_en", en_gen_r, 1);
    chk("idle_abort_start_busy", busy, 1);
    step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_gen_r_busy", busy, 0);
    chk("abort_gen_r_done", done, 0);
    chk("abort_gen_r_err", err, 0);

    // Reset mid-operation.
    start = 1; skip_fors = 1; sig_word_vld = 1;
    step();
    start = 0; sig_word_vld = 0;
    step();
    rstn = 0;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_sig_words", sig_words, 0);
    chk("midrst_root_sel", root_sel, 0);
    chk("midrst_done_err", {done, err}, 0);
    rstn = 1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
